// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT input-side read requester.
//   t_block      : one 512-bit cache line as carried by the read channel and FIFO
//   t_line_addr  : cache-line address
//   t_rd_state   : requester sequencing states
package fft_pkg;

  localparam int FFT_FIFO_DEPTH = 8;
  localparam int FFT_ADDR_W     = 42;

  typedef logic [511:0]            t_block;
  typedef logic [FFT_ADDR_W-1:0]   t_line_addr;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_rd_state;

endpackage

// File: rtl/fft_credit_ctr.sv
// Outstanding-request counter and FIFO credit check.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear (new fetch)
//   inc          : a request is issued this cycle
//   dec          : a response is accepted this cycle
//   fifo_free    : free slots reported by the downstream FIFO
//   outstanding  : requests issued but not yet answered
//   room         : outstanding + 1 < fifo_free (one FIFO slot is never used)
module fft_credit_ctr #(
  parameter int LEN_W = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] fifo_free,
  output logic [LEN_W-1:0] outstanding,
  output logic             room
);

  logic [LEN_W:0] out_plus_one;
  logic [LEN_W:0] free_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (clr) begin
      outstanding <= '0;
    end else begin
      // issue and response together leave the count unchanged
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // one bit wider so the +1 never wraps
  assign out_plus_one = {1'b0, outstanding} + {{LEN_W{1'b0}}, 1'b1};
  assign free_ext     = {{(LEN_W + 1 - CNT_W){1'b0}}, fifo_free};
  assign room         = out_plus_one < free_ext;

endmodule

// File: rtl/fft_rd_requester.sv
// Fetches a run of cache lines from host memory into the FFT input FIFO.
// Requests are throttled by FIFO free-slot credits so every accepted
// response has a slot waiting for it.
// Optional feature: define FFT_RD_REQUESTER_PERF_EN to add the stall_cycles
// output (cycles in REQ with lines left to request but no issue).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle pulse, honoured only while idle
//   base_addr, num_lines: fetch descriptor, captured on start
//   rd_req_valid/addr   : registered read request
//   rd_req_almost_full  : read channel backpressure
//   rd_rsp_valid/data   : in-order read responses
//   enq_en, enq_data    : FIFO enqueue side
//   fifo_not_full       : FIFO not_full
//   fifo_free           : FIFO free-slot count
//   busy, done          : activity flag, end-of-fetch pulse
//   overflow_err        : sticky, response arrived while FIFO full
module fft_rd_requester
  import fft_pkg::*;
#(
  parameter int FIFO_DEPTH = FFT_FIFO_DEPTH,
  parameter int CNT_W      = FIFO_DEPTH / 2,
  parameter int ADDR_W     = 42,
  parameter int LEN_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_lines,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_almost_full,
  input  logic              rd_rsp_valid,
  input  t_block            rd_rsp_data,
  output t_block            enq_data,
  output logic              enq_en,
  input  logic              fifo_not_full,
  input  logic [CNT_W-1:0]  fifo_free,
  output logic              busy,
  output logic              done,
  output logic              overflow_err
`ifdef FFT_RD_REQUESTER_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  t_rd_state         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  num_lines_q;
  logic [LEN_W-1:0]  req_cnt;
  logic [LEN_W-1:0]  rsp_cnt;
  logic [LEN_W-1:0]  outstanding;
  logic              room;
  logic              start_fire;
  logic              can_issue;
  logic              rsp_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    start_fire = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_fire = 1'b1;
          state_d    = REQ;
        end
      end
      REQ:     if (req_cnt == num_lines_q) state_d = DRAIN;
      DRAIN:   if (rsp_cnt == num_lines_q) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign can_issue = (state_q == REQ) && (req_cnt < num_lines_q) &&
                     !rd_req_almost_full && room;

  // responses are never stalled; a full FIFO is only flagged
  assign rsp_acc  = rd_rsp_valid && busy;
  assign enq_en   = rsp_acc;
  assign enq_data = rd_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      base_q       <= '0;
      num_lines_q  <= '0;
      req_cnt      <= '0;
      rsp_cnt      <= '0;
      overflow_err <= 1'b0;
    end else begin
      rd_req_valid <= can_issue;
      if (start_fire) begin
        base_q      <= base_addr;
        num_lines_q <= num_lines;
        req_cnt     <= '0;
        rsp_cnt     <= '0;
      end else begin
        if (can_issue) begin
          rd_req_addr <= base_q + ADDR_W'(req_cnt);
          req_cnt     <= req_cnt + 1'b1;
        end
        if (rsp_acc) rsp_cnt <= rsp_cnt + 1'b1;
      end
      if (rsp_acc && !fifo_not_full) overflow_err <= 1'b1;
    end
  end

  fft_credit_ctr #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_credit (
    .clk         (clk),
    .rst         (reset),
    .clr         (start_fire),
    .inc         (can_issue),
    .dec         (rsp_acc),
    .fifo_free   (fifo_free),
    .outstanding (outstanding),
    .room        (room)
  );

`ifdef FFT_RD_REQUESTER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (start_fire) begin
      stall_cycles <= '0;
    end else if ((state_q == REQ) && (req_cnt < num_lines_q) && !can_issue &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fft_rd_requester.md
Name: fft_rd_requester

Overview:
- Feeds the FFT input FIFO from host memory.
- Issues cache-line read requests over the CCI-P-style read channel, starting at a base line address, for a programmed number of 512-bit lines.
- Pushes every in-order read response into the FIFO's enq side.
- Throttles requests using the FIFO's free-slot count, so an accepted response can never hit a full FIFO.

Parameters:
- FIFO_DEPTH, 8: depth of the downstream FIFO. Usable capacity is FIFO_DEPTH-1 lines.
- CNT_W, FIFO_DEPTH/2: width of the FIFO occupancy and free-slot counters.
- ADDR_W, 42: cache-line address width.
- LEN_W, 32: width of the line-count registers.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first line address; captured on start.
- num_lines  in  LEN_W  lines to fetch; captured on start.
- rd_req_valid  out  1  registered read request strobe.
- rd_req_addr  out  ADDR_W  registered request line address.
- rd_req_almost_full  in  1  read channel backpressure; no new request while high.
- rd_rsp_valid  in  1  read response strobe; responses arrive in request order.
- rd_rsp_data  in  512  response line (t_block).
- enq_data  out  512  to FIFO enq_data.
- enq_en  out  1  to FIFO enq_en.
- fifo_not_full  in  1  from FIFO not_full.
- fifo_free  in  CNT_W  from FIFO dec_counter (FIFO_DEPTH - occupancy).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final response has been enqueued.
- overflow_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: state IDLE. rd_req_valid, enq_en, busy, done and overflow_err are 0. rd_req_addr is 0. All counters are 0.
- Internal counters (LEN_W): req_cnt (requests issued), rsp_cnt (responses received), outstanding (requests issued but not yet responded).
- Credit rule:
  - can_issue = (state==REQ) && (req_cnt < num_lines_q) && !rd_req_almost_full && (outstanding + 1 < fifo_free).
  - The condition reserves the one slot the FIFO never fills.
- Request timing:
  - When can_issue is true in cycle T, rd_req_valid=1 and rd_req_addr = base_q + req_cnt in cycle T+1.
  - req_cnt and outstanding increment at the same edge.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Response handling:
  - Response path is combinational: enq_en = rd_rsp_valid && busy, and enq_data = rd_rsp_data.
  - rsp_cnt increments and outstanding decrements on every accepted response.
  - Issue and response in the same cycle: outstanding is unchanged and both other counters update.
  - rd_rsp_valid while IDLE is ignored and not enqueued.
  - rd_rsp_valid while fifo_not_full=0 sets overflow_err. The line is dropped, but the counters still advance so the fetch terminates.
- States:
  - IDLE: on start, capture base_addr and num_lines, clear the counters, go to REQ.
  - REQ: issue per the credit rule. When req_cnt reaches num_lines_q, go to DRAIN.
  - DRAIN: wait until rsp_cnt equals num_lines_q, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
  - num_lines=0: path is IDLE -> REQ -> DRAIN -> DONE with no requests, so done pulses 3 cycles after start.
- start while busy is ignored.
- Asynchronous reset mid-fetch returns to IDLE immediately. Responses still in flight afterwards are ignored, per the IDLE rule above.

Optional Feature:
- Macro FFT_RD_REQUESTER_PERF_EN.
- Defined: adds output stall_cycles (32 bits). It counts cycles in REQ where req_cnt < num_lines_q but can_issue is 0. It is cleared on start, saturates at all-ones, and holds its value in IDLE.
- Undefined: no port and no counter logic.

Decomposition:
- fft_pkg holds:
  - t_block (512-bit line).
  - t_line_addr (ADDR_W bits).
  - t_rd_state enum {IDLE, REQ, DRAIN, DONE}.
  - Default constant FFT_FIFO_DEPTH=8.
- One sub-module is natural: fft_credit_ctr. It holds the outstanding counter with inc/dec/simultaneous handling and produces the can-issue compare against fifo_free.

Test Plan:
- Basic fetch: base=0x100, num_lines=4, FIFO drained every cycle, 3-cycle response latency.
  - Requests go to 0x100..0x103, the first one 2 cycles after start.
  - 4 enq_en pulses carry the data in order.
  - done pulses once; busy drops the cycle after.
- Credit limit: num_lines=20, FIFO never dequeued.
  - Exactly 7 requests are issued, then rd_req_valid stays 0.
  - Dequeue 1 line: 1 further request follows.
  - overflow_err stays 0 throughout.
- Backpressure: hold rd_req_almost_full=1 for 10 cycles mid-fetch.
  - No rd_req_valid during the hold; issue resumes the cycle after release.
  - With PERF_EN, stall_cycles is at least 10.
- Zero length: num_lines=0.
  - No request issued; done pulses 3 cycles after start.
  - A second start during busy is ignored.
- Reset mid-fetch: assert reset after 3 of 8 requests.
  - All outputs return to 0 immediately.
  - A late rd_rsp_valid produces no enq_en.
  - A new start with base=0x200 fetches cleanly.
- Forced overflow: drive rd_rsp_valid with fifo_not_full=0.
  - overflow_err=1 and stays 1 until reset.
